// File: rtl/harvard_pkg.sv
// Constants and types shared across the Harvard system (processor, progmem,
// datamem and the instruction prefetch stage).
package harvard_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 32;
  localparam int STAT_W  = 16;

  localparam logic [ADDR_W-1:0] RESET_PC = 8'h00;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [STAT_W-1:0] sat_inc16(input logic [STAT_W-1:0] value);
    if (value == 16'hFFFF) begin
      sat_inc16 = value;
    end else begin
      sat_inc16 = value + 16'h0001;
    end
  endfunction

endpackage

// File: rtl/instr_prefetch_if.sv
// Prefetch bus: program-memory read port, redirect request and the
// instruction handshake toward the processor.
interface instr_prefetch_if #(
  parameter int ADDR_W  = harvard_pkg::ADDR_W,
  parameter int INSTR_W = harvard_pkg::INSTR_W
);

  logic [ADDR_W-1:0]  mem_addr;
  logic [INSTR_W-1:0] mem_data;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_addr;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_ready;

  modport master (
    output mem_addr,
    input  mem_data,
    input  redirect,
    input  redirect_addr,
    output instr_valid,
    output instr,
    output instr_pc,
    input  instr_ready
  );

  modport slave (
    input  mem_addr,
    output mem_data,
    output redirect,
    output redirect_addr,
    input  instr_valid,
    input  instr,
    input  instr_pc,
    output instr_ready
  );

endinterface

// File: rtl/prefetch_fifo.sv
// Synchronous power-of-two FIFO with flush; the head reads as zero when empty.
module prefetch_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualify requests against occupancy; flush overrides both
  always_comb begin
    do_push_s = push && (count_r != CNT_W'(DEPTH)) && !flush;
    do_pop_s  = pop && (count_r != {CNT_W{1'b0}}) && !flush;
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (flush) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_r <= do_push_s ? wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1} : wr_ptr_r;
      rd_ptr_r <= do_pop_s  ? rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1} : rd_ptr_r;
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage is not reset: an empty queue masks whatever it holds
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Head entry, forced to zero when empty
  always_comb begin
    if (count_r != {CNT_W{1'b0}}) begin
      head = mem_r[rd_ptr_r];
    end else begin
      head = {WIDTH{1'b0}};
    end
  end

  assign count = count_r;

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetch stage: owns the fetch PC, queues {pc, instr} pairs and
// serves redirects. Optional PREFETCH_STATS_EN adds stall/flush counters.
module instr_prefetch #(
  parameter int ADDR_W  = harvard_pkg::ADDR_W,
  parameter int INSTR_W = harvard_pkg::INSTR_W,
  parameter int DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  instr_prefetch_if.master       bus,
  output logic [$clog2(DEPTH):0] count
`ifdef PREFETCH_STATS_EN
  ,
  output logic [15:0]            stall_cnt,
  output logic [15:0]            flush_cnt
`endif
);

  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = ADDR_W + INSTR_W;

  logic [ADDR_W-1:0]  fetch_pc_r;
  logic [CNT_W-1:0]   count_s;
  logic [ENTRY_W-1:0] head_s;
  logic               full_s;
  logic               push_s;
  logic               pop_s;

  // Fetch whenever there is room; a redirect suppresses both push and pop
  always_comb begin
    full_s = (count_s == CNT_W'(DEPTH));
    if (bus.redirect) begin
      push_s = 1'b0;
      pop_s  = 1'b0;
    end else begin
      push_s = !full_s;
      pop_s  = (count_s != {CNT_W{1'b0}}) && bus.instr_ready;
    end
  end

  // Fetch PC: redirect target wins, otherwise advance on each push
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_r <= ADDR_W'(harvard_pkg::RESET_PC);
    end else if (bus.redirect) begin
      fetch_pc_r <= bus.redirect_addr;
    end else if (push_s) begin
      fetch_pc_r <= fetch_pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      fetch_pc_r <= fetch_pc_r;
    end
  end

  prefetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (bus.redirect),
    .push  (push_s),
    .pop   (pop_s),
    .din   ({fetch_pc_r, bus.mem_data}),
    .head  (head_s),
    .count (count_s)
  );

  assign bus.mem_addr    = fetch_pc_r;
  assign bus.instr_valid = (count_s != {CNT_W{1'b0}});
  assign bus.instr_pc    = head_s[ENTRY_W-1:INSTR_W];
  assign bus.instr       = head_s[INSTR_W-1:0];
  assign count           = count_s;

`ifdef PREFETCH_STATS_EN
  // Saturating activity counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= 16'h0000;
      flush_cnt <= 16'h0000;
    end else begin
      if (full_s && !bus.instr_ready) begin
        stall_cnt <= harvard_pkg::sat_inc16(stall_cnt);
      end else begin
        stall_cnt <= stall_cnt;
      end
      if (bus.redirect) begin
        flush_cnt <= harvard_pkg::sat_inc16(flush_cnt);
      end else begin
        flush_cnt <= flush_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_prefetch.sv
// Scoreboard bench for instr_prefetch: a queue of expected {pc, instr} entries
// is filled on modelled fetches and drained against the DUT head.
module tb_instr_prefetch;
  import harvard_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] count;

  instr_prefetch_if bus_if ();

`ifdef PREFETCH_STATS_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
  int          exp_stall;
  int          exp_flush;
`endif

  instr_prefetch #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus_if),
    .count (count)
`ifdef PREFETCH_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // progmem[i] = i * 0x01010101
  assign bus_if.mem_data = {4{bus_if.mem_addr}};

  fetch_entry_t      sb[$];
  logic [ADDR_W-1:0] m_pc;
  int                total = 0;
  int                bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic fetch_entry_t mk_entry(input logic [ADDR_W-1:0] pc);
    fetch_entry_t e;
    e.pc    = pc;
    e.instr = {4{pc}};
    return e;
  endfunction

  task automatic check_state();
    check_eq("valid", 64'(bus_if.instr_valid), 64'(sb.size() != 0));
    check_eq("count", 64'(count), 64'(sb.size()));
    check_eq("mem_addr", 64'(bus_if.mem_addr), 64'(m_pc));
    if (sb.size() != 0) begin
      check_eq("head_pc", 64'(bus_if.instr_pc), 64'(sb[0].pc));
      check_eq("head_instr", 64'(bus_if.instr), 64'(sb[0].instr));
    end else begin
      check_eq("empty_pc", 64'(bus_if.instr_pc), 64'd0);
      check_eq("empty_instr", 64'(bus_if.instr), 64'd0);
    end
`ifdef PREFETCH_STATS_EN
    check_eq("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
    check_eq("flush_cnt", 64'(flush_cnt), 64'(exp_flush));
`endif
  endtask

  // Called #1 after a rising edge: drive inputs, model the edge, then check
  task automatic step(input logic rdy, input logic redir, input logic [ADDR_W-1:0] raddr);
    logic do_push;
    logic do_pop;
    bus_if.instr_ready   = rdy;
    bus_if.redirect      = redir;
    bus_if.redirect_addr = raddr;
    do_push = (sb.size() < DEPTH) && !redir;
    do_pop  = (sb.size() != 0) && rdy && !redir;
`ifdef PREFETCH_STATS_EN
    if (sb.size() == DEPTH && !rdy && exp_stall < 65535) exp_stall++;
    if (redir && exp_flush < 65535) exp_flush++;
`endif
    if (redir) begin
      sb.delete();
      m_pc = raddr;
    end else begin
      if (do_pop) void'(sb.pop_front());
      if (do_push) begin
        sb.push_back(mk_entry(m_pc));
        m_pc = m_pc + 8'h01;
      end
    end
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic async_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("arst_valid", 64'(bus_if.instr_valid), 64'd0);
    check_eq("arst_count", 64'(count), 64'd0);
    check_eq("arst_mem_addr", 64'(bus_if.mem_addr), 64'd0);
    sb.delete();
    m_pc = 8'h00;
`ifdef PREFETCH_STATS_EN
    exp_stall = 0;
    exp_flush = 0;
`endif
    @(posedge clk);
    #1;
    check_state();
    rst = 1'b0;
  endtask

  initial begin
    rst                  = 1'b1;
    bus_if.instr_ready   = 1'b0;
    bus_if.redirect      = 1'b0;
    bus_if.redirect_addr = 8'h00;
    m_pc                 = 8'h00;
`ifdef PREFETCH_STATS_EN
    exp_stall = 0;
    exp_flush = 0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check_state();
    rst = 1'b0;

    // Streaming with ready held high
    repeat (12) step(1'b1, 1'b0, 8'h00);

    // Mid-stream async reset, then fill with ready low
    async_reset();
    repeat (10) step(1'b0, 1'b0, 8'h00);
    check_eq("full_count", 64'(count), 64'd4);
    check_eq("full_mem_addr", 64'(bus_if.mem_addr), 64'd4);
    repeat (10) step(1'b1, 1'b0, 8'h00);

    // Redirect with three entries queued
    check_eq("pre_redir_count", 64'(count), 64'd3);
    step(1'b1, 1'b1, 8'h40);
    check_eq("redir_valid", 64'(bus_if.instr_valid), 64'd0);
    check_eq("redir_count", 64'(count), 64'd0);
    step(1'b1, 1'b0, 8'h00);
    check_eq("redir_pc0", 64'(bus_if.instr_pc), 64'h40);
    step(1'b1, 1'b0, 8'h00);
    check_eq("redir_pc1", 64'(bus_if.instr_pc), 64'h41);

    // Back-to-back redirects: last one wins
    step(1'b1, 1'b1, 8'h10);
    step(1'b1, 1'b1, 8'h20);
    step(1'b1, 1'b0, 8'h00);
    check_eq("b2b_pc", 64'(bus_if.instr_pc), 64'h20);

    // Address wrap 0xFE -> 0xFF -> 0x00
    step(1'b1, 1'b1, 8'hFE);
    step(1'b1, 1'b0, 8'h00);
    check_eq("wrap_pc_fe", 64'(bus_if.instr_pc), 64'hFE);
    step(1'b1, 1'b0, 8'h00);
    check_eq("wrap_pc_ff", 64'(bus_if.instr_pc), 64'hFF);
    step(1'b1, 1'b0, 8'h00);
    check_eq("wrap_pc_00", 64'(bus_if.instr_pc), 64'h00);
    check_eq("wrap_instr_00", 64'(bus_if.instr), 64'h0);

    // Five full-stall cycles and two redirects from a clean reset
    async_reset();
    repeat (9) step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h80);
    step(1'b1, 1'b1, 8'h90);
`ifdef PREFETCH_STATS_EN
    check_eq("stats_stall5", 64'(stall_cnt), 64'd5);
    check_eq("stats_flush2", 64'(flush_cnt), 64'd2);
`endif
    step(1'b1, 1'b0, 8'h00);
    check_eq("stats_pc", 64'(bus_if.instr_pc), 64'h90);

    // Random ready with occasional redirects
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0), 8'($urandom_range(0, 255)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_prefetch.md
# instr_prefetch

Instruction prefetch stage between the combinational program memory and the processor's instruction port in the Harvard system. It owns the fetch program counter, reads one 32-bit instruction per cycle into a small FIFO, and hands instructions to the processor with a valid/ready handshake. A redirect input handles branch, jump and call targets: it flushes the queue and restarts fetch at a new address.

## Interface
Parameters:
- ADDR_W, 8, program address width
- INSTR_W, 32, instruction width
- DEPTH, 4, FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- mem_addr  out  ADDR_W  address to program memory (equals fetch_pc)
- mem_data  in  INSTR_W  program memory read data, valid in the same cycle
- redirect  in  1  flush and restart fetch
- redirect_addr  in  ADDR_W  new fetch address, sampled when redirect=1
- instr_valid  out  1  FIFO head valid
- instr  out  INSTR_W  head instruction
- instr_pc  out  ADDR_W  address of head instruction
- instr_ready  in  1  processor accepts head
- count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- State: fetch_pc, FIFO storage of {pc, instr}, rd_ptr, wr_ptr, count.
- Reset values: fetch_pc=0, pointers=0, count=0, instr_valid=0, instr=0, instr_pc=0, mem_addr=0.
- instr_valid = (count != 0). instr and instr_pc are the head entry, or 0 when empty.
- Push condition: count < DEPTH and redirect=0. On push, write {fetch_pc, mem_data} at wr_ptr and increment fetch_pc modulo 2^ADDR_W (0xFF wraps to 0x00).
- Pop condition: instr_valid && instr_ready && redirect=0.
- Push and pop in the same cycle: count is unchanged. A push is not allowed when full, even if a pop happens that cycle. Throughput is one instruction per cycle whenever count < DEPTH.
- Redirect (highest priority): count, rd_ptr and wr_ptr clear to 0; fetch_pc <= redirect_addr; no push.
  - A head handshake in the redirect cycle counts as delivered to the processor, but the entry is discarded with the rest of the queue.
  - Back-to-back redirects: the last one wins.
- Full: count=DEPTH, no fetch. mem_addr still shows fetch_pc.
- Reset asserted mid-operation clears all state immediately. Fetch resumes from address 0 on the first clk edge after deassertion.

## Timing
- Fetch to output: an instruction pushed at edge N is visible at the head after edge N if the queue was empty before it.
- After reset release: the first edge pushes address 0 and instr_valid rises. Addresses 0,1,2,3 then appear on consecutive cycles while instr_ready=1.
- Redirect penalty: the redirect edge clears the queue. The next edge pushes redirect_addr, so instr_valid is low for exactly one cycle after the redirect edge.
- No combinational path from instr_ready to mem_addr. mem_addr depends only on registers.

## Configuration
- PREFETCH_STATS_EN defined: adds outputs stall_cnt (16 bit) and flush_cnt (16 bit). Both reset to 0 and saturate at 0xFFFF.
  - stall_cnt increments each cycle with count=DEPTH and instr_ready=0.
  - flush_cnt increments on each redirect.
- PREFETCH_STATS_EN undefined: the ports and counters are absent. All other behaviour is identical.

## Structure
- Shared package harvard_pkg holds:
  - ADDR_W and INSTR_W constants, shared with processor, progmem and datamem.
  - typedef fetch_entry_t {pc, instr}.
  - RESET_PC = 0.
- One sub-module: prefetch_fifo, a parameterised synchronous FIFO with push, pop, flush, count and head outputs. instr_prefetch keeps the PC logic and the redirect/handshake control.

## Test plan
- Reset then instr_ready=1 continuously, with progmem[i]=i*0x01010101 -> instr_pc sequence 0,1,2,… one per cycle and matching instr.
- instr_ready=0 for 10 cycles after reset -> count saturates at 4, mem_addr holds 4. Releasing ready -> pcs 0..7 in order with no gaps.
- Redirect to 0x40 while 3 entries are queued -> next cycle instr_valid=0 and count=0. The following cycle instr_pc=0x40, then 0x41.
- fetch_pc = 0xFE with ready=1 -> instr_pc sequence 0xFE, 0xFF, 0x00 (wrap).
- Assert rst asynchronously mid-stream, between edges -> instr_valid and count go to 0 before the next edge. After release, fetch restarts at 0.
- With PREFETCH_STATS_EN: 5 full stall cycles and 2 redirects -> stall_cnt=5, flush_cnt=2.
